// File: rtl/victim_select_pkg.sv
// Shared cache package: victim-select FSM encoding and default LFSR seed.
package victim_select_pkg;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_PICK = 2'd1;
   localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

   localparam int unsigned DEFAULT_LFSR_BITS = 5;
   localparam logic [DEFAULT_LFSR_BITS-1:0] DEFAULT_SEED = 5'h1f;

endpackage : victim_select_pkg

// File: rtl/victim_lfsr.sv
// Free-running Fibonacci LFSR used as the random victim source.
module victim_lfsr
   import victim_select_pkg::*;
#(
   parameter int unsigned            LFSR_BITS = DEFAULT_LFSR_BITS,
   parameter logic [LFSR_BITS-1:0]   SEED      = LFSR_BITS'(DEFAULT_SEED)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [LFSR_BITS-1:0] data
);

   logic [LFSR_BITS-1:0] r_data;

   // Step once per clock: new MSB is d[MSB]^d[1], the rest shifts right.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= SEED;
      end else begin
         r_data <= {r_data[LFSR_BITS-1] ^ r_data[1], r_data[LFSR_BITS-1:1]};
      end
   end

   assign data = r_data;

endmodule : victim_lfsr

// File: rtl/victim_select.sv
// Cache victim-way selector: prefers invalid ways, else a random unlocked way.
module victim_select
   import victim_select_pkg::*;
#(
   parameter int unsigned            WAYS      = 4,
   parameter int unsigned            WAY_BITS  = 2,
   parameter int unsigned            LFSR_BITS = DEFAULT_LFSR_BITS,
   parameter logic [LFSR_BITS-1:0]   SEED      = LFSR_BITS'(DEFAULT_SEED)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [WAYS-1:0]     valid_bits,
   input  logic [WAYS-1:0]     lock_bits,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [WAY_BITS-1:0] resp_way,
   output logic                resp_invalid,
   output logic                resp_none
);

   localparam logic [WAY_BITS-1:0] LAST_TRY = WAY_BITS'(WAYS - 1);

   logic [STATE_W-1:0]   r_state;
   logic [WAYS-1:0]      r_valid;
   logic [WAYS-1:0]      r_lock;
   logic [WAY_BITS-1:0]  r_try_cnt;
   logic                 r_resp_valid;
   logic [WAY_BITS-1:0]  r_resp_way;
   logic                 r_resp_invalid;
   logic                 r_resp_none;

   logic [STATE_W-1:0]   w_state_nxt;
   logic [WAYS-1:0]      w_valid_nxt;
   logic [WAYS-1:0]      w_lock_nxt;
   logic [WAY_BITS-1:0]  w_try_nxt;
   logic                 w_resp_valid_nxt;
   logic [WAY_BITS-1:0]  w_resp_way_nxt;
   logic                 w_resp_invalid_nxt;
   logic                 w_resp_none_nxt;

   logic [LFSR_BITS-1:0] w_lfsr;
   logic [WAYS-1:0]      w_free;
   logic                 w_free_any;
   logic [WAY_BITS-1:0]  w_free_idx;
   logic [WAY_BITS-1:0]  w_unlocked_idx;
   logic                 w_all_locked;
   logic [WAY_BITS-1:0]  w_cand;
   logic                 w_cand_locked;

   victim_lfsr #(
      .LFSR_BITS (LFSR_BITS),
      .SEED      (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .data  (w_lfsr)
   );

   // Only the low WAY_BITS of the LFSR pick a candidate.
   generate
      if (LFSR_BITS > WAY_BITS) begin : g_lfsr_hi
         logic w_unused_lfsr_hi;
         assign w_unused_lfsr_hi = ^w_lfsr[LFSR_BITS-1:WAY_BITS];
      end
   endgenerate

   assign w_free        = ~r_valid & ~r_lock;
   assign w_all_locked  = &r_lock;
   assign w_cand        = w_lfsr[WAY_BITS-1:0];
   assign w_cand_locked = r_lock[w_cand];

   // Lowest-index invalid+unlocked way and lowest-index unlocked way.
   always_comb begin
      w_free_any     = 1'b0;
      w_free_idx     = '0;
      w_unlocked_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (w_free[i]) begin
            w_free_any = 1'b1;
            w_free_idx = WAY_BITS'(i);
         end
         if (!r_lock[i]) begin
            w_unlocked_idx = WAY_BITS'(i);
         end
      end
   end

   // Next-state and next-output logic for the IDLE/PICK/RESP sequence.
   always_comb begin
      w_state_nxt        = r_state;
      w_valid_nxt        = r_valid;
      w_lock_nxt         = r_lock;
      w_try_nxt          = r_try_cnt;
      w_resp_valid_nxt   = r_resp_valid;
      w_resp_way_nxt     = r_resp_way;
      w_resp_invalid_nxt = r_resp_invalid;
      w_resp_none_nxt    = r_resp_none;

      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_valid_nxt = valid_bits;
               w_lock_nxt  = lock_bits;
               w_try_nxt   = '0;
               w_state_nxt = ST_PICK;
            end
         end

         ST_PICK: begin
            if (w_free_any) begin
               w_resp_way_nxt     = w_free_idx;
               w_resp_invalid_nxt = 1'b1;
               w_resp_none_nxt    = 1'b0;
               w_resp_valid_nxt   = 1'b1;
               w_state_nxt        = ST_RESP;
            end else if (w_all_locked) begin
               w_resp_way_nxt     = '0;
               w_resp_invalid_nxt = 1'b0;
               w_resp_none_nxt    = 1'b1;
               w_resp_valid_nxt   = 1'b1;
               w_state_nxt        = ST_RESP;
            end else if (!w_cand_locked) begin
               w_resp_way_nxt     = w_cand;
               w_resp_invalid_nxt = 1'b0;
               w_resp_none_nxt    = 1'b0;
               w_resp_valid_nxt   = 1'b1;
               w_state_nxt        = ST_RESP;
            end else if (r_try_cnt == LAST_TRY) begin
               // Random tries exhausted: fall back to a deterministic pick.
               w_resp_way_nxt     = w_unlocked_idx;
               w_resp_invalid_nxt = 1'b0;
               w_resp_none_nxt    = 1'b0;
               w_resp_valid_nxt   = 1'b1;
               w_state_nxt        = ST_RESP;
            end else begin
               w_try_nxt = r_try_cnt + WAY_BITS'(1);
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               w_resp_valid_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
         end

         default: begin
            w_resp_valid_nxt = 1'b0;
            w_state_nxt      = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_valid        <= '0;
         r_lock         <= '0;
         r_try_cnt      <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_way     <= '0;
         r_resp_invalid <= 1'b0;
         r_resp_none    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_valid        <= w_valid_nxt;
         r_lock         <= w_lock_nxt;
         r_try_cnt      <= w_try_nxt;
         r_resp_valid   <= w_resp_valid_nxt;
         r_resp_way     <= w_resp_way_nxt;
         r_resp_invalid <= w_resp_invalid_nxt;
         r_resp_none    <= w_resp_none_nxt;
      end
   end

   // Ready must be low in reset and high right after release, so it is
   // decoded from state and gated by rst_n rather than registered.
   assign req_ready    = rst_n & (r_state == ST_IDLE);
   assign resp_valid   = r_resp_valid;
   assign resp_way     = r_resp_way;
   assign resp_invalid = r_resp_invalid;
   assign resp_none    = r_resp_none;

endmodule : victim_select

// File: tb/tb_victim_select.sv
// Bench for victim_select: directed cases plus random requests vs a reference model.
module tb_victim_select;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] valid_bits;
   logic [3:0] lock_bits;
   logic       resp_valid;
   logic       resp_ready;
   logic [1:0] resp_way;
   logic       resp_invalid;
   logic       resp_none;

   int checks = 0;
   int errors = 0;
   int m_lfsr;

   victim_select dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .valid_bits   (valid_bits),
      .lock_bits    (lock_bits),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_way     (resp_way),
      .resp_invalid (resp_invalid),
      .resp_none    (resp_none)
   );

   always #5 clk = ~clk;

   function automatic int step(input int l);
      return ((((l >> 4) ^ (l >> 1)) & 1) << 4) | (l >> 1);
   endfunction

   // Reference random source: 5-bit value stepping every clock from 0x1f.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 31;
      else        m_lfsr <= step(m_lfsr);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected result of one request, given captured bits and the LFSR in the first PICK cycle.
   task automatic predict(input int v, input int l, input int lf,
                          output int way, output int inv, output int none, output int cyc);
      int lowest_unlocked;
      way = 0; inv = 0; none = 0; cyc = 1;
      for (int i = 3; i >= 0; i--) begin
         if (((v >> i) & 1) == 0 && ((l >> i) & 1) == 0) begin
            way = i; inv = 1;
         end
      end
      if (inv == 1) return;
      if ((l & 15) == 15) begin
         none = 1; way = 0; return;
      end
      lowest_unlocked = 0;
      for (int i = 3; i >= 0; i--) if (((l >> i) & 1) == 0) lowest_unlocked = i;
      for (int t = 0; t < 4; t++) begin
         if (((l >> (lf & 3)) & 1) == 0) begin
            way = lf & 3; cyc = t + 1; return;
         end
         if (t == 3) begin
            way = lowest_unlocked; cyc = 4; return;
         end
         lf = step(lf);
      end
   endtask

   // Issue one request at a negedge and check latency, result, hold and handshake.
   task automatic do_req(input string tag, input int v, input int l, input int hold);
      int way, inv, none, cyc, k, lf;
      check({tag, ".req_ready"}, int'(req_ready), 1);
      req_valid  = 1'b1;
      valid_bits = 4'(v);
      lock_bits  = 4'(l);
      lf = step(m_lfsr);
      predict(v, l, lf, way, inv, none, cyc);
      @(negedge clk);
      req_valid  = 1'b0;
      valid_bits = 4'($urandom);
      lock_bits  = 4'($urandom);
      check({tag, ".pick_lfsr"}, int'(dut.w_lfsr), lf);
      k = 1;
      while (!resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, ".latency"}, k, cyc + 1);
      check({tag, ".way"}, int'(resp_way), way);
      check({tag, ".invalid"}, int'(resp_invalid), inv);
      check({tag, ".none"}, int'(resp_none), none);
      check({tag, ".busy"}, int'(req_ready), 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, ".hold_valid"}, int'(resp_valid), 1);
         check({tag, ".hold_way"}, int'(resp_way), way);
         check({tag, ".hold_flags"}, int'({resp_invalid, resp_none}), (inv << 1) | none);
         check({tag, ".hold_busy"}, int'(req_ready), 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, ".done_valid"}, int'(resp_valid), 0);
      check({tag, ".done_ready"}, int'(req_ready), 1);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      int v, l;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      valid_bits = '0;
      lock_bits  = '0;
      repeat (3) @(negedge clk);
      check("rst.resp_valid", int'(resp_valid), 0);
      check("rst.resp_way", int'(resp_way), 0);
      check("rst.resp_invalid", int'(resp_invalid), 0);
      check("rst.resp_none", int'(resp_none), 0);
      check("rst.req_ready", int'(req_ready), 0);
      check("rst.lfsr", int'(dut.w_lfsr), 31);
      rst_n = 1'b1;
      #1;

      // Request in the very first cycle after release.
      do_req("all_valid", 15, 0, 0);
      do_req("one_invalid", 4'b1011, 0, 0);

      // Locked way 3 from a fresh reset: three locked candidates then fallback-free pick.
      reset_dut();
      do_req("lock3", 15, 4'b1000, 0);
      do_req("all_locked", 15, 15, 0);
      do_req("stall", 15, 0, 5);

      // Reset while in PICK: request abandoned, LFSR reseeded.
      reset_dut();
      check("mid.ready", int'(req_ready), 1);
      req_valid  = 1'b1;
      valid_bits = 4'hf;
      lock_bits  = 4'b1000;
      @(negedge clk);
      req_valid = 1'b0;
      check("mid.in_pick", int'(req_ready), 0);
      rst_n = 1'b0;
      #1;
      check("mid.resp_valid", int'(resp_valid), 0);
      check("mid.req_ready", int'(req_ready), 0);
      check("mid.lfsr", int'(dut.w_lfsr), 31);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid.ready_after", int'(req_ready), 1);
      check("mid.no_resp", int'(resp_valid), 0);
      do_req("after_mid", 15, 0, 0);

      // Random requests; bias locks toward heavy so retries and fallback are hit.
      for (int n = 0; n < 60; n++) begin
         v = int'($urandom_range(0, 15));
         l = int'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) v = 15;
         if ($urandom_range(0, 2) == 0) l = l | int'($urandom_range(0, 15));
         do_req("random", v, l, int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_victim_select
